// File: rtl/mul_arbiter.sv
// mul_arbiter: two requesters share one combinational 4x4 multiplier.
// Each operation runs IDLE -> LOAD -> CALC -> DONE -> IDLE.
// Optional macro RR_FAIR_EN selects round-robin tie breaking. When it is
// undefined, requester 0 wins every tie.
//
// Handshake: reqN is a level request sampled in IDLE. gntN pulses for the
// single LOAD cycle, and the operands were captured on the edge that entered
// LOAD. The requester must drop reqN after gntN or it is served again. doneN
// pulses for the single DONE cycle, and pro_out is valid from then until the
// next result.

// Shared combinational unsigned 4x4 -> 8 multiplier.
module mul_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    // Zero-extend both operands so the full 8-bit product is kept.
    assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module mul_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [3:0]       x0,
    input  logic [3:0]       y0,
    input  logic             req1,
    input  logic [3:0]       x1,
    input  logic [3:0]       y1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [7:0]       pro_out,
    output logic             busy,
    output logic [CNT_W-1:0] ops_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] opa;
    logic [3:0] opb;
    logic       owner;   // 0: requester 0 owns the in-flight operation
    logic       win;     // requester selected if a grant happens this cycle
    logic       start;   // IDLE -> LOAD this cycle
    logic [7:0] prod;

`ifdef RR_FAIR_EN
    logic       last;    // requester served most recently
`endif

    assign dbg_state = state;
    assign start     = (state == IDLE) && (req0 || req1);

    // Arbitration: a single request always wins; a tie goes by configuration.
    always_comb begin
        win = 1'b0;
`ifdef RR_FAIR_EN
        if (req0 && req1)
            win = ~last;
        else
            win = ~req0;
`else
        win = ~req0;
`endif
    end

    // The only multiplier, fed solely from the captured operands.
    mul_4x4 u_mul (
        .a (opa),
        .b (opb),
        .p (prod)
    );

    // State register; asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and the owner's grant/done pulses.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (req0 || req1)
                    state_nxt = LOAD;
            end
            LOAD: begin
                gnt0      = ~owner;
                gnt1      = owner;
                state_nxt = CALC;
            end
            CALC: begin
                state_nxt = DONE;
            end
            DONE: begin
                done0     = ~owner;
                done1     = owner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, result register and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa     <= 4'd0;
            opb     <= 4'd0;
            owner   <= 1'b0;
            pro_out <= 8'd0;
            ops_cnt <= '0;
`ifdef RR_FAIR_EN
            last    <= 1'b1;
`endif
        end else begin
            if (start) begin
                opa   <= win ? x1 : x0;
                opb   <= win ? y1 : y0;
                owner <= win;
`ifdef RR_FAIR_EN
                last  <= win;
`endif
            end
            if (state == CALC)
                pro_out <= prod;
            if (state == DONE)
                ops_cnt <= ops_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter, built with CNT_W=2 so counter wrap is reached quickly.
// Honours RR_FAIR_EN in its reference model the same way the design does.
module tb_mul_arbiter;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             req0;
    logic [3:0]       x0;
    logic [3:0]       y0;
    logic             req1;
    logic [3:0]       x1;
    logic [3:0]       y1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [7:0]       pro_out;
    logic             busy;
    logic [CNT_W-1:0] ops_cnt;
    logic [1:0]       dbg_state;

    mul_arbiter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .x0        (x0),
        .y0        (y0),
        .req1      (req1),
        .x1        (x1),
        .y1        (y1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .pro_out   (pro_out),
        .busy      (busy),
        .ops_cnt   (ops_cnt),
        .dbg_state (dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    int         passed;
    int         total;
    int         model_cnt;       // completed operations since reset
    int         model_last;      // requester served most recently
    logic [7:0] model_pro;       // last result delivered
    logic [7:0] exp_q[$];        // results of operations in flight

    // Expected winner from the arbitration rules.
    function automatic int pick_winner(input logic r0, input logic r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
`ifdef RR_FAIR_EN
        return (model_last == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // One full operation. Starts and ends on a negedge with the DUT in IDLE.
    task automatic run_op(input logic r0, input logic r1,
                          input logic [3:0] a0, input logic [3:0] b0,
                          input logic [3:0] a1, input logic [3:0] b1,
                          input bit hold, input bit zero_after);
        int         w;
        logic [7:0] exp_p;
        logic [1:0] exp_c;
        req0 = r0; req1 = r1; x0 = a0; y0 = b0; x1 = a1; y1 = b1;
        w = pick_winner(r0, r1);
        model_last = w;
        exp_q.push_back((w == 0) ? 8'(int'(a0) * int'(b0)) : 8'(int'(a1) * int'(b1)));
        @(posedge clk);
        @(negedge clk);
        // LOAD cycle
        total++;
        if (gnt0 !== (w == 0) || gnt1 !== (w == 1)) $display("FAIL load_gnt: gnt0=%b gnt1=%b expected winner %0d", gnt0, gnt1, w);
        else passed++;
        total++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b1) $display("FAIL load_flags: done0=%b done1=%b busy=%b expected 0 0 1", done0, done1, busy);
        else passed++;
        if (!hold) begin
            req0 = 1'b0; req1 = 1'b0;
        end
        if (zero_after) begin
            x0 = 4'd0; y0 = 4'd0; x1 = 4'd0; y1 = 4'd0;
        end else begin
            x0 = 4'($urandom_range(0, 15)); y0 = 4'($urandom_range(0, 15));
            x1 = 4'($urandom_range(0, 15)); y1 = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        // CALC cycle
        total++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b1)
            $display("FAIL calc_flags: gnt=%b%b done=%b%b busy=%b expected 00 00 1", gnt0, gnt1, done0, done1, busy);
        else passed++;
        @(negedge clk);
        // DONE cycle
        exp_p = exp_q.pop_front();
        model_pro = exp_p;
        total++;
        if (done0 !== (w == 0) || done1 !== (w == 1) || gnt0 !== 1'b0 || gnt1 !== 1'b0)
            $display("FAIL done_pulse: done0=%b done1=%b gnt=%b%b expected owner %0d", done0, done1, gnt0, gnt1, w);
        else passed++;
        total++;
        if (pro_out !== exp_p) $display("FAIL done_product: pro_out=%0d expected %0d", pro_out, exp_p);
        else passed++;
        model_cnt++;
        @(negedge clk);
        // Back in IDLE
        exp_c = 2'(model_cnt % 4);
        total++;
        if (ops_cnt !== exp_c) $display("FAIL ops_cnt: got %0d expected %0d", ops_cnt, exp_c);
        else passed++;
        total++;
        if (busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || pro_out !== model_pro)
            $display("FAIL idle_hold: busy=%b done=%b%b pro_out=%0d expected 0 00 %0d", busy, done0, done1, pro_out, model_pro);
        else passed++;
    endtask

    task automatic test_reset();
        total++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_flags: gnt=%b%b done=%b%b busy=%b expected all 0", gnt0, gnt1, done0, done1, busy);
        else passed++;
        total++;
        if (pro_out !== 8'd0 || ops_cnt !== 2'd0) $display("FAIL reset_regs: pro_out=%0d ops_cnt=%0d expected 0 0", pro_out, ops_cnt);
        else passed++;
    endtask

    task automatic test_single_op();
        run_op(1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_max_operands();
        run_op(1'b0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd15, 1'b0, 1'b0);
    endtask

    task automatic test_operand_stability();
        run_op(1'b1, 1'b0, 4'd7, 4'd9, 4'd2, 4'd2, 1'b0, 1'b1);
    endtask

    task automatic test_tie();
        for (int i = 0; i < 4; i++)
            run_op(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), (i != 3), 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            run_op(sel[0], sel[1], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_op();
        req0 = 1'b1; x0 = 4'd6; y0 = 4'd7;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        // CALC cycle: abort asynchronously
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || pro_out !== 8'd0 || ops_cnt !== 2'd0 || done0 !== 1'b0 || done1 !== 1'b0)
            $display("FAIL abort_now: busy=%b pro_out=%0d ops_cnt=%0d done=%b%b expected 0 0 0 00", busy, pro_out, ops_cnt, done0, done1);
        else passed++;
        #1;
        rst = 1'b0;
        model_cnt = 0; model_last = 1; model_pro = 8'd0; exp_q.delete();
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || ops_cnt !== 2'd0 || pro_out !== 8'd0)
            $display("FAIL abort_after: busy=%b done=%b%b ops_cnt=%0d pro_out=%0d expected 0 00 0 0", busy, done0, done1, ops_cnt, pro_out);
        else passed++;
    endtask

    task automatic test_wrap();
        // First op is a tie, so the pointer reset value is exercised too.
        run_op(1'b1, 1'b1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_op(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // Sequence of scenarios and the final report.
    initial begin
        passed = 0; total = 0;
        model_cnt = 0; model_last = 1; model_pro = 8'd0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        x0 = 4'd0; y0 = 4'd0; x1 = 4'd0; y1 = 4'd0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_single_op();
        test_max_operands();
        test_operand_stability();
        test_tie();
        test_random();
        test_reset_mid_op();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
